// File: rtl/crc16_frame_ctrl.sv
// crc16_frame_ctrl: frame sequencer for a word-wide CRC-16/CCITT (GEN appends CRC, CHECK verifies residue)
module crc16_frame_ctrl #(
  parameter int MAX_WORDS = 1024,
  parameter int CNT_W     = 16,
  localparam int LW       = $clog2(MAX_WORDS + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             mode,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [15:0]      s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [15:0]      m_data,
  output logic             m_last,
  input  logic             stat_clear,
  output logic             busy,
  output logic             done,
  output logic [15:0]      crc_value,
  output logic             crc_err,
  output logic             len_err,
  output logic [LW-1:0]    frame_len,
  output logic [CNT_W-1:0] frames_ok_cnt,
  output logic [CNT_W-1:0] frames_err_cnt
);
  typedef enum logic [1:0] {IDLE, DATA, APPEND, STATUS} state_t;
  state_t state_q, state_d;
  logic [15:0] crc_q, crc_d, m_data_q, m_data_d, crc_value_q, crc_value_d;
  logic mode_q, mode_d, lerr_q, lerr_d, m_valid_q, m_valid_d, m_last_q, m_last_d;
  logic done_q, done_d, crc_err_q, crc_err_d, len_err_q, len_err_d;
  logic [LW-1:0] len_q, len_d, frame_len_q, frame_len_d;
  logic [CNT_W-1:0] ok_q, ok_d, err_q, err_d;
  logic idle, slot_free, acc, md, crc_bad;
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [15:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 16; i++)
      r = {r[14:0], 1'b0} ^ ((r[15] ^ d[15-i]) ? 16'h1021 : 16'h0000);
    return r;
  endfunction
  assign idle      = state_q == IDLE;
  assign slot_free = !m_valid_q || m_ready;
  // reset_n gates s_ready so the source sees no acceptance while held in reset
  assign s_ready   = reset_n && (idle || state_q == DATA) && slot_free;
  assign acc       = s_valid && s_ready;
  assign md        = idle ? mode : mode_q;
  assign crc_bad   = mode_q && ((crc_q != 16'h0000) || (len_q < LW'(2)));
  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    mode_d      = mode_q;
    len_d       = len_q;
    lerr_d      = lerr_q;
    m_valid_d   = slot_free ? 1'b0 : m_valid_q;
    m_data_d    = m_data_q;
    m_last_d    = m_last_q;
    done_d      = 1'b0;
    crc_value_d = crc_value_q;
    crc_err_d   = crc_err_q;
    len_err_d   = len_err_q;
    frame_len_d = frame_len_q;
    ok_d        = ok_q;
    err_d       = err_q;
    if (acc) begin
      m_valid_d = 1'b1;
      m_data_d  = s_data;
      m_last_d  = md && s_last;
      crc_d     = crc_step(idle ? 16'hFFFF : crc_q, s_data);
      mode_d    = md;
      len_d     = idle ? LW'(1) : (len_q == LW'(MAX_WORDS)) ? len_q : len_q + LW'(1);
      lerr_d    = !idle && (lerr_q || len_q == LW'(MAX_WORDS));
      state_d   = s_last ? (md ? STATUS : APPEND) : DATA;
    end
    if (state_q == APPEND && slot_free) begin
      m_valid_d = 1'b1;
      m_data_d  = crc_q;
      m_last_d  = 1'b1;
      state_d   = STATUS;
    end
    if (state_q == STATUS) begin
      done_d      = 1'b1;
      crc_value_d = crc_q;
      crc_err_d   = crc_bad;
      len_err_d   = lerr_q;
      frame_len_d = len_q;
      ok_d        = (!crc_bad && !lerr_q && !(&ok_q)) ? ok_q + CNT_W'(1) : ok_q;
      err_d       = ((crc_bad || lerr_q) && !(&err_q)) ? err_q + CNT_W'(1) : err_q;
      state_d     = IDLE;
    end
    if (stat_clear) begin
      ok_d  = '0;
      err_d = '0;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      crc_q       <= 16'hFFFF;
      mode_q      <= 1'b0;
      len_q       <= '0;
      lerr_q      <= 1'b0;
      m_valid_q   <= 1'b0;
      m_data_q    <= 16'h0000;
      m_last_q    <= 1'b0;
      done_q      <= 1'b0;
      crc_value_q <= 16'h0000;
      crc_err_q   <= 1'b0;
      len_err_q   <= 1'b0;
      frame_len_q <= '0;
      ok_q        <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      mode_q      <= mode_d;
      len_q       <= len_d;
      lerr_q      <= lerr_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_last_q    <= m_last_d;
      done_q      <= done_d;
      crc_value_q <= crc_value_d;
      crc_err_q   <= crc_err_d;
      len_err_q   <= len_err_d;
      frame_len_q <= frame_len_d;
      ok_q        <= ok_d;
      err_q       <= err_d;
    end
  end
  assign m_valid        = m_valid_q;
  assign m_data         = m_data_q;
  assign m_last         = m_last_q;
  assign busy           = !idle;
  assign done           = done_q;
  assign crc_value      = crc_value_q;
  assign crc_err        = crc_err_q;
  assign len_err        = len_err_q;
  assign frame_len      = frame_len_q;
  assign frames_ok_cnt  = ok_q;
  assign frames_err_cnt = err_q;
endmodule
